// File: rtl/dram_controller.sv
// rtl/dram_controller.sv - 68000 DRAM controller with CAS-before-RAS refresh
//
// Purpose: runs the RAS/CAS/WE sequence for 68000 bus cycles to a 2 MB DRAM
// window and inserts CAS-before-RAS refresh cycles at a fixed interval.
//
// Ports:
//   CLK, RST_n          24 MHz clock, asynchronous active-low reset
//   AS_n, UDS_n, LDS_n  68000 address strobe and upper/lower data strobes
//   RW                  68000 direction (1 = read)
//   CS_DRAM_n           decoded DRAM select
//   ADDR[20:1]          CPU word address within the DRAM window
//   MA[9:0]             multiplexed DRAM address (row, then column)
//   RAS_n               row strobe
//   CASU_n, CASL_n      upper/lower byte column strobes
//   WE_n                DRAM write enable
//   DTACK_DRAM_n        transfer acknowledge to the system controller
//   REFRESH_OVERRUN     sticky flag: a refresh request was lost
module dram_controller #(
    parameter int REFRESH_PERIOD   = 360,
    parameter int PRECHARGE_CYCLES = 2,
    parameter int REF_RAS_CYCLES   = 3
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        AS_n,
    input  logic        UDS_n,
    input  logic        LDS_n,
    input  logic        RW,
    input  logic        CS_DRAM_n,
    input  logic [20:1] ADDR,
    output logic [9:0]  MA,
    output logic        RAS_n,
    output logic        CASU_n,
    output logic        CASL_n,
    output logic        WE_n,
    output logic        DTACK_DRAM_n,
    output logic        REFRESH_OVERRUN
);
    localparam int RCW = $clog2(REFRESH_PERIOD + 1);
    localparam logic [RCW-1:0] REF_RELOAD = RCW'(REFRESH_PERIOD - 1);
    localparam logic [7:0]     PRE_LOAD   = 8'(PRECHARGE_CYCLES - 1);
    localparam logic [7:0]     RAS_LOAD   = 8'(REF_RAS_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ROW, COL, CAS, PRE, REF_CAS, REF_RAS} state_t;

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [RCW-1:0] ref_cnt_q, ref_cnt_d;
    logic           pending_q, pending_d;
    logic           overrun_q, overrun_d;
    logic           as_high_q, as_high_d;
    logic [9:0]     ma_q, ma_d;
    logic           ras_n_q, ras_n_d;
    logic           casu_n_q, casu_n_d;
    logic           casl_n_q, casl_n_d;
    logic           we_n_q, we_n_d;
    logic           dtack_n_q, dtack_n_d;
    logic           expire;

    assign expire = (ref_cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ma_d      = ma_q;
        ras_n_d   = ras_n_q;
        casu_n_d  = casu_n_q;
        casl_n_d  = casl_n_q;
        we_n_d    = we_n_q;
        dtack_n_d = dtack_n_q;

        // Free-running interval counter, independent of bus activity.
        ref_cnt_d = expire ? REF_RELOAD : ref_cnt_q - RCW'(1);
        pending_d = pending_q | expire;
        overrun_d = overrun_q | (expire & pending_q);
        // An access may only start once AS_n has been seen high since the last one.
        as_high_d = as_high_q | AS_n;

        case (state_q)
            IDLE: begin
                ma_d = ADDR[20:11];
                // The expiry itself counts as a request so that refresh wins
                // against a CPU cycle arriving on the same edge.
                if (pending_q || expire) begin
                    state_d   = REF_CAS;
                    pending_d = 1'b0;
                    casu_n_d  = 1'b0;
                    casl_n_d  = 1'b0;
                end else if (!CS_DRAM_n && !AS_n && as_high_q) begin
                    state_d   = ROW;
                    as_high_d = 1'b0;
                    ras_n_d   = 1'b0;
                end
            end
            ROW, COL, CAS: begin
                if (AS_n) begin
                    state_d   = PRE;
                    cnt_d     = PRE_LOAD;
                    ras_n_d   = 1'b1;
                    casu_n_d  = 1'b1;
                    casl_n_d  = 1'b1;
                    we_n_d    = 1'b1;
                    dtack_n_d = 1'b1;
                end else if (state_q == ROW) begin
                    state_d = COL;
                    ma_d    = ADDR[10:1];
                    we_n_d  = RW;
                end else begin
                    // Data strobes are followed live; DTACK waits for either one.
                    state_d   = CAS;
                    we_n_d    = RW;
                    casu_n_d  = UDS_n;
                    casl_n_d  = LDS_n;
                    dtack_n_d = UDS_n & LDS_n;
                end
            end
            PRE: begin
                if (cnt_q == 8'd0) begin
                    state_d = IDLE;
                    ma_d    = ADDR[20:11];
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            REF_CAS: begin
                state_d = REF_RAS;
                cnt_d   = RAS_LOAD;
                ras_n_d = 1'b0;
            end
            REF_RAS: begin
                if (cnt_q == 8'd0) begin
                    state_d  = PRE;
                    cnt_d    = PRE_LOAD;
                    ras_n_d  = 1'b1;
                    casu_n_d = 1'b1;
                    casl_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                ras_n_d   = 1'b1;
                casu_n_d  = 1'b1;
                casl_n_d  = 1'b1;
                we_n_d    = 1'b1;
                dtack_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            ref_cnt_q <= REF_RELOAD;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
            as_high_q <= 1'b0;
            ma_q      <= 10'd0;
            ras_n_q   <= 1'b1;
            casu_n_q  <= 1'b1;
            casl_n_q  <= 1'b1;
            we_n_q    <= 1'b1;
            dtack_n_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_cnt_q <= ref_cnt_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            as_high_q <= as_high_d;
            ma_q      <= ma_d;
            ras_n_q   <= ras_n_d;
            casu_n_q  <= casu_n_d;
            casl_n_q  <= casl_n_d;
            we_n_q    <= we_n_d;
            dtack_n_q <= dtack_n_d;
        end
    end

    assign MA              = ma_q;
    assign RAS_n           = ras_n_q;
    assign CASU_n          = casu_n_q;
    assign CASL_n          = casl_n_q;
    assign WE_n            = we_n_q;
    assign DTACK_DRAM_n    = dtack_n_q;
    assign REFRESH_OVERRUN = overrun_q;

endmodule

// File: tb/tb_dram_controller.sv
// tb/tb_dram_controller.sv - directed self-checking bench for dram_controller
module tb_dram_controller;
    logic        CLK = 1'b0;
    logic        RST_n;
    logic        AS_n, UDS_n, LDS_n, RW, CS_DRAM_n;
    logic [20:1] ADDR;
    logic [9:0]  MA;
    logic        RAS_n, CASU_n, CASL_n, WE_n, DTACK_DRAM_n, REFRESH_OVERRUN;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // {RAS_n, CASU_n, CASL_n, WE_n, DTACK_DRAM_n}
    logic [4:0] strb;
    assign strb = {RAS_n, CASU_n, CASL_n, WE_n, DTACK_DRAM_n};

    dram_controller #(
        .REFRESH_PERIOD  (360),
        .PRECHARGE_CYCLES(2),
        .REF_RAS_CYCLES  (3)
    ) dut (
        .CLK            (CLK),
        .RST_n          (RST_n),
        .AS_n           (AS_n),
        .UDS_n          (UDS_n),
        .LDS_n          (LDS_n),
        .RW             (RW),
        .CS_DRAM_n      (CS_DRAM_n),
        .ADDR           (ADDR),
        .MA             (MA),
        .RAS_n          (RAS_n),
        .CASU_n         (CASU_n),
        .CASL_n         (CASL_n),
        .WE_n           (WE_n),
        .DTACK_DRAM_n   (DTACK_DRAM_n),
        .REFRESH_OVERRUN(REFRESH_OVERRUN)
    );

    always #10 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cyc %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic bus_idle();
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; RW = 1'b1; CS_DRAM_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ref_seq [0:9];
        ref_seq = '{5'b00011, 5'b00011, 5'b00011, 5'b11111, 5'b11111,
                    5'b11111, 5'b01111, 5'b01111, 5'b00010, 5'b00010};

        // Reset state
        bus_idle();
        ADDR  = 20'h12345;
        RST_n = 1'b0;
        tick(); tick();
        check_val("rst_strobes", strb, 5'b11111);
        check_val("rst_ma", MA, 10'd0);
        check_val("rst_ovr", REFRESH_OVERRUN, 1'b0);
        RST_n = 1'b1;
        cyc   = 0;

        // Read of word 0x12345, both strobes
        tick();
        check_val("idle_ma_row", MA, 10'h048);
        check_val("idle_strobes", strb, 5'b11111);
        tick();
        AS_n = 1'b0; CS_DRAM_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0; RW = 1'b1;
        tick();
        check_val("rd_row_strobes", strb, 5'b01111);
        check_val("rd_row_ma", MA, 10'h048);
        tick();
        check_val("rd_col_strobes", strb, 5'b01111);
        check_val("rd_col_ma", MA, 10'h345);
        tick();
        check_val("rd_cas_strobes", strb, 5'b00010);
        bus_idle();
        tick();
        check_val("rd_pre_strobes", strb, 5'b11111);

        // Byte write to 0xFFC01, LDS_n delayed; access requested during PRE
        ADDR = 20'hFFC01; AS_n = 1'b0; CS_DRAM_n = 1'b0; RW = 1'b0;
        tick();
        check_val("pre2_strobes", strb, 5'b11111);
        tick();
        check_val("pre_to_idle", strb, 5'b11111);
        check_val("wr_idle_ma", MA, 10'h3FF);
        tick();
        check_val("wr_row_strobes", strb, 5'b01111);
        check_val("wr_row_ma", MA, 10'h3FF);
        tick();
        check_val("wr_col_strobes", strb, 5'b01101);
        check_val("wr_col_ma", MA, 10'h001);
        tick();
        check_val("wr_cas_wait1", strb, 5'b01101);
        tick();
        check_val("wr_cas_wait2", strb, 5'b01101);
        LDS_n = 1'b0;
        tick();
        check_val("wr_cas_lower", strb, 5'b01000);
        bus_idle();
        tick();
        check_val("wr_pre_strobes", strb, 5'b11111);

        // Access requested on the refresh expiry edge
        ADDR = 20'h12345;
        wait_to(359);
        check_val("pre_ref_idle", strb, 5'b11111);
        AS_n = 1'b0; CS_DRAM_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0; RW = 1'b1;
        tick();
        check_val("ref_cas_first", strb, 5'b10011);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val($sformatf("ref_seq_%0d", i), strb, ref_seq[i]);
        end

        // Long access spanning two expiries
        wait_to(719);
        check_val("ovr_before_1st", REFRESH_OVERRUN, 1'b0);
        tick();
        check_val("long_dtack_held", strb, 5'b00010);
        check_val("ovr_at_1st", REFRESH_OVERRUN, 1'b0);
        wait_to(1079);
        check_val("ovr_before_2nd", REFRESH_OVERRUN, 1'b0);
        tick();
        check_val("ovr_at_2nd", REFRESH_OVERRUN, 1'b1);
        wait_to(1160);
        bus_idle();
        tick(); check_val("late_pre1", strb, 5'b11111);
        tick(); check_val("late_pre2", strb, 5'b11111);
        tick(); check_val("late_idle", strb, 5'b11111);
        tick(); check_val("late_ref_cas", strb, 5'b10011);
        tick(); check_val("late_ref_ras1", strb, 5'b00011);
        tick(); check_val("late_ref_ras2", strb, 5'b00011);
        tick(); check_val("late_ref_ras3", strb, 5'b00011);
        tick(); check_val("late_ref_pre", strb, 5'b11111);
        tick(); tick(); tick();
        check_val("single_refresh", strb, 5'b11111);
        check_val("ovr_sticky", REFRESH_OVERRUN, 1'b1);

        // Reset pulsed while in CAS
        AS_n = 1'b0; CS_DRAM_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0; RW = 1'b1;
        tick(); tick(); tick();
        check_val("pre_rst_cas", strb, 5'b00010);
        #2;
        RST_n = 1'b0;
        #2;
        check_val("async_rst_strobes", strb, 5'b11111);
        check_val("async_rst_ovr", REFRESH_OVERRUN, 1'b0);
        check_val("async_rst_ma", MA, 10'd0);
        tick();
        RST_n = 1'b1;
        cyc   = 0;
        tick(); check_val("post_rst_no_access1", strb, 5'b11111);
        tick(); check_val("post_rst_no_access2", strb, 5'b11111);
        bus_idle();
        wait_to(359);
        check_val("post_rst_before_ref", strb, 5'b11111);
        tick();
        check_val("post_rst_first_ref", strb, 5'b10011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
